mux_scan_serializer: RTL and testbench
======================================

// Module: mux_scan_serializer
//
// PURPOSE
// - Upstream sequencer for the 8-to-1 mux stage. Turns it into a parallel-to-serial converter.
// - Accepts a parallel word over a valid/ready handshake and holds it on the mux data inputs.
// - Steps the mux select through every index, one per clock, and registers the mux output.
// - Presents the registered bits as a framed serial stream. Back-to-back words produce a gap-free stream.
//
// PARAMETERS
// - WIDTH      8   word width = number of mux inputs (power of 2, >= 2)
// - SEL_W      3   select width = $clog2(WIDTH); must match the mux select
// - MSB_FIRST  0   0: select counts 0..WIDTH-1; 1: select counts WIDTH-1..0
//
// PORTS
// - clk          in   1      rising-edge clock
// - rst          in   1      asynchronous, active-high reset
// - in_data      in   WIDTH  parallel word to serialize
// - in_valid     in   1      in_data valid; must hold with in_data stable until accepted
// - in_ready     out  1      block can accept a word this cycle
// - mux_in       out  WIDTH  held word, drives the mux data inputs
// - sel          out  SEL_W  drives the mux select
// - mux_out      in   1      combinational mux result for the current sel
// - ser_out      out  1      registered serial bit
// - ser_valid    out  1      ser_out holds a valid bit
// - frame_start  out  1      high with the first bit of each word
// - done         out  1      high with the last bit of each word
//
// BEHAVIOUR
// - Reset values (async on rst rising, held while rst high):
//   - state=IDLE, mux_in=0, sel=0.
//   - ser_out, ser_valid, frame_start and done are all 0.
//   - in_ready is forced 0 while rst is high.
// - States:
//   - IDLE: in_ready=1.
//   - SHIFT: in_ready=1 only when sel==LAST; otherwise 0.
// - FIRST/LAST indices: FIRST=0 and LAST=WIDTH-1 when MSB_FIRST=0; reversed when MSB_FIRST=1.
// - Accept = in_valid & in_ready at a rising edge. On accept:
//   - mux_in <= in_data, sel <= FIRST, state <= SHIFT.
//   - Bit index 0 is flagged as the frame's first bit.
// - In SHIFT, every edge does all of the following:
//   - ser_out <= mux_out, ser_valid <= 1.
//   - frame_start <= (sel==FIRST and this is the frame's first bit).
//   - done <= (sel==LAST).
// - In SHIFT, sel advances by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1), except at LAST:
//   - accept at LAST: load the new word, sel <= FIRST, stay in SHIFT.
//   - otherwise: state <= IDLE, sel holds.
// - In IDLE without accept: ser_valid, frame_start and done <= 0. ser_out holds its last value.
// - Latency:
//   - The first bit appears on ser_out one edge after the accepting edge.
//   - A word occupies exactly WIDTH consecutive ser_valid cycles.
//   - done coincides with the WIDTH-th bit.
// - Throughput: back-to-back accepts give a continuous ser_valid, with no bubble between words.
// - Handshake:
//   - in_valid while in_ready=0 is ignored; no data is captured.
//   - in_ready is combinational from state and sel only, never from in_valid.
// - Reset mid-frame:
//   - Outputs return to reset values immediately.
//   - The partial frame is discarded and never resumed.
//   - The first accept after rst deasserts starts a clean frame with frame_start.
// - sel never leaves the range 0..WIDTH-1. mux_in changes only on accept.
//
// TESTING (WIDTH=8; bit k = ser_out k edges after accept)
// - Reset: assert rst mid-cycle -> all outputs 0 with no clock edge; in_ready=1 on the first cycle after deassert.
// - LSB-first: accept 8'b01010011 -> ser_out 1,1,0,0,1,0,1,0.
//   - sel 0..7; frame_start on bit 1, done on bit 8; IDLE after.
// - MSB_FIRST=1: accept 8'b01010011 -> ser_out 0,1,0,1,0,0,1,1; sel 7..0.
// - Back-to-back: in_valid held high with 8'b11010011 then 8'b01000011.
//   - Second accept lands on the sel==7 cycle.
//   - Result: 16 contiguous valid bits 1,1,0,0,1,0,1,1, 1,1,0,0,0,0,1,0.
//   - frame_start pulses twice; done pulses twice.
// - Stall: in_valid=1 with 8'b11000010 while a frame is mid-shift.
//   - Not accepted until sel==7; no corruption of the current word.
// - Reset mid-frame: rst after bit 4 of 8'b01110011.
//   - ser_valid drops immediately.
//   - Next word 8'b10010011 serializes as 1,1,0,0,1,0,0,1 with frame_start.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial sequencer for an external WIDTH-to-1 mux: holds the accepted
// word on the mux data inputs, walks the select one index per clock and registers the result.
module mux_scan_serializer #(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done,
  output logic             dbg_state
);

  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] FIRST   = (MSB_FIRST != 0) ? IDX_MAX : '0;
  localparam logic [SEL_W-1:0] LAST    = (MSB_FIRST != 0) ? '0 : IDX_MAX;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Handshake: a word is taken on a rising edge where in_valid && in_ready; the
  // producer holds in_valid and in_data stable until then. in_ready depends only
  // on state and sel, so a new word can land on the LAST bit for a gap-free stream.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mux_in_d;
  logic [SEL_W-1:0] sel_d;
  logic             first_q, first_d;
  logic             ser_out_d, ser_valid_d, frame_start_d, done_d;
  logic             accept;

  assign dbg_state = (state_q == SHIFT);

  always_comb begin
    in_ready      = ~rst & ((state_q == IDLE) | (sel == LAST));
    accept        = in_valid & in_ready;
    state_d       = state_q;
    mux_in_d      = mux_in;
    sel_d         = sel;
    first_d       = first_q;
    ser_out_d     = ser_out;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mux_in_d = in_data;
          sel_d    = FIRST;
          first_d  = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        ser_out_d     = mux_out;
        ser_valid_d   = 1'b1;
        frame_start_d = (sel == FIRST) & first_q;
        done_d        = (sel == LAST);
        first_d       = 1'b0;
        if (sel == LAST) begin
          if (accept) begin
            mux_in_d = in_data;
            sel_d    = FIRST;
            first_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (MSB_FIRST != 0) begin
          sel_d = sel - SEL_W'(1);
        end else begin
          sel_d = sel + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_in      <= '0;
      sel         <= '0;
      first_q     <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_in      <= mux_in_d;
      sel         <= sel_d;
      first_q     <= first_d;
      ser_out     <= ser_out_d;
      ser_valid   <= ser_valid_d;
      frame_start <= frame_start_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: an LSB-first and an MSB-first instance share the
// input handshake; each has its own behavioural mux and expected-bit queue.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;

  logic       in_ready_l, ser_out_l, ser_valid_l, fs_l, done_l, st_l, mux_out_l;
  logic [7:0] mux_in_l;
  logic [2:0] sel_l;
  logic       in_ready_m, ser_out_m, ser_valid_m, fs_m, done_m, st_m, mux_out_m;
  logic [7:0] mux_in_m;
  logic [2:0] sel_m;

  // Entries are {ser_out, frame_start, done}
  logic [2:0] exp_l[$];
  logic [2:0] exp_m[$];

  int tests_run = 0;
  int failed    = 0;
  int run_len   = 0;
  int max_run   = 0;

  assign mux_out_l = mux_in_l[sel_l];
  assign mux_out_m = mux_in_m[sel_m];

  mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .mux_in(mux_in_l), .sel(sel_l), .mux_out(mux_out_l), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .frame_start(fs_l), .done(done_l), .dbg_state(st_l)
  );

  mux_scan_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .mux_in(mux_in_m), .sel(sel_m), .mux_out(mux_out_m), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .frame_start(fs_m), .done(done_m), .dbg_state(st_m)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      exp_l.push_back({w[k],     1'(k == 0), 1'(k == 7)});
      exp_m.push_back({w[7 - k], 1'(k == 0), 1'(k == 7)});
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send_word(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready_l) begin
        check("ready_msb_match", {31'd0, in_ready_m}, 32'd1);
        push_word(w);
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ser_valid", {30'd0, ser_valid_l, ser_valid_m}, 32'd0);
    check("rst_ser_out",   {30'd0, ser_out_l, ser_out_m}, 32'd0);
    check("rst_flags",     {28'd0, fs_l, fs_m, done_l, done_m}, 32'd0);
    check("rst_mux_in",    {16'd0, mux_in_l, mux_in_m}, 32'd0);
    check("rst_sel",       {26'd0, sel_l, sel_m}, 32'd0);
    check("rst_in_ready",  {30'd0, in_ready_l, in_ready_m}, 32'd0);
    check("rst_state",     {30'd0, st_l, st_m}, 32'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (ser_valid_l) begin
        if (exp_l.size() == 0) check("lsb_extra_bit", 32'd1, 32'd0);
        else check("lsb_bit", {29'd0, ser_out_l, fs_l, done_l}, {29'd0, exp_l.pop_front()});
      end
      if (ser_valid_m) begin
        if (exp_m.size() == 0) check("msb_extra_bit", 32'd1, 32'd0);
        else check("msb_bit", {29'd0, ser_out_m, fs_m, done_m}, {29'd0, exp_m.pop_front()});
      end
      run_len = ser_valid_l ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    logic [7:0] w;
    // reset asserted mid-cycle must clear outputs without a clock edge
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", {30'd0, in_ready_l, in_ready_m}, 32'd3);
    @(negedge clk);

    // single word, select sweep in both directions
    send_word(8'b01010011);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("sel_lsb", {29'd0, sel_l}, k);
      check("sel_msb", {29'd0, sel_m}, 7 - k);
      check("mux_in_hold", {24'd0, mux_in_l}, 32'h53);
      @(negedge clk);
    end
    check("idle_after_word", {30'd0, st_l, st_m}, 32'd0);
    check("ready_in_idle", {30'd0, in_ready_l, in_ready_m}, 32'd3);
    @(negedge clk);
    check("single_q_empty", exp_l.size() + exp_m.size(), 32'd0);

    // back-to-back words form one unbroken 16-bit run
    max_run = 0;
    send_word(8'b11010011);
    send_word(8'b01000011);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b_run_len", max_run, 32'd16);

    // word offered mid-frame waits for the LAST bit and leaves the held word alone
    send_word(8'hA5);
    in_data  = 8'b11000010;
    in_valid = 1'b1;
    repeat (3) begin
      check("stall_mux_in", {24'd0, mux_in_l}, 32'hA5);
      check("stall_ready", {31'd0, in_ready_l}, 32'd0);
      @(negedge clk);
    end
    send_word(8'b11000010);
    in_valid = 1'b0;
    check("stall_loaded", {24'd0, mux_in_m}, 32'hC2);
    repeat (10) @(negedge clk);

    // reset mid-frame discards the partial word
    send_word(8'b01110011);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    exp_l.delete();
    exp_m.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(8'b10010011);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);

    // random words with random idle gaps
    for (int n = 0; n < 12; n++) begin
      w = 8'($urandom_range(0, 255));
      send_word(w);
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    check("final_q_lsb", exp_l.size(), 32'd0);
    check("final_q_msb", exp_m.size(), 32'd0);
    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
